// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction store fronted by a one-word fetch buffer: hits return combinationally,
// misses fill after LATENCY cycles while busywait stalls the CPU; prog writes keep buffer and fill coherent.
module instr_fetch_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_BYTES = 4,
  parameter int LATENCY    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc,
  input  logic                    fetch_req,
  output logic [8*WORD_BYTES-1:0] instruction,
  output logic                    busywait,
  output logic                    valid,
  output logic                    misaligned,
  input  logic                    prog_en,
  input  logic [ADDR_WIDTH-1:0]   prog_addr,
  input  logic [7:0]              prog_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int WW    = 8 * WORD_BYTES;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  logic [7:0]            mem [DEPTH];
  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] tag;
  logic [WW-1:0]         buf_data;
  logic                  buf_valid;
  logic [WW-1:0]         fill_data;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic                  hit;
  logic                  miss;
  logic                  hits_buf;
  logic                  hits_req;
  logic                  fill;
  logic                  unused_bits;

  // True when byte address a falls inside the word starting at base, with wrap at the top.
  function automatic logic in_word(input logic [ADDR_WIDTH-1:0] a,
                                   input logic [ADDR_WIDTH-1:0] base);
    logic [ADDR_WIDTH-1:0] off;
    off = a - base;
    return 32'(off) < 32'(WORD_BYTES);
  endfunction

  assign pc_addr     = pc[ADDR_WIDTH-1:0];
  assign unused_bits = ^pc[31:ADDR_WIDTH];
  assign hit         = buf_valid && (tag == pc_addr);
  assign miss        = fetch_req && !hit;
  assign hits_buf    = prog_en && buf_valid && in_word(prog_addr, tag);
  assign hits_req    = prog_en && in_word(prog_addr, req_addr);
  assign fill        = !reset && (state == WAIT) && !hits_req && (cnt == '0);

  assign misaligned  = |(pc_addr & ALIGN_MASK);
  assign valid       = !reset && hit;
  assign busywait    = !reset && ((state == WAIT) || miss);
  assign instruction = valid ? buf_data : '0;

  always_comb begin
    fill_data = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      fill_data[8*k +: 8] = mem[req_addr + ADDR_WIDTH'(k)];
    end
  end

  // The array is not reset so a preload done under reset survives.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      buf_data <= fill_data;
      tag      <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      buf_valid <= 1'b0;
      req_addr  <= '0;
    end else begin
      if (hits_buf) begin
        buf_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (miss) begin
            state    <= WAIT;
            req_addr <= pc_addr;
            cnt      <= CNT_LOAD;
          end
        end
        WAIT: begin
          // A write into the in-flight word restarts the read so the fill sees the new bytes.
          if (hits_req) begin
            cnt <= CNT_LOAD;
          end else if (cnt == '0) begin
            buf_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, byte-address width of the instruction store (2^ADDR_WIDTH bytes).
REQ-002 Parameter WORD_BYTES, default 4, bytes per instruction word; legal values 1, 2, 4, 8.
REQ-003 Parameter LATENCY, default 2, miss read latency in clock cycles; legal range 1..15.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high. Ports are listed below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc  in  32  byte address of the requested instruction; only bits [ADDR_WIDTH-1:0] are used.
REQ-008 fetch_req  in  1  fetch request, qualifying pc.
REQ-009 instruction  out  8*WORD_BYTES  fetched word, little-endian (byte at pc in bits [7:0]).
REQ-010 busywait  out  1  high while the requested word is not yet available; the CPU SHALL stall pc.
REQ-011 valid  out  1  instruction holds the word for the current pc.
REQ-012 misaligned  out  1  pc is not a multiple of WORD_BYTES.
REQ-013 prog_en  in  1  byte write enable for preloading or patching the store.
REQ-014 prog_addr  in  ADDR_WIDTH  byte write address.
REQ-015 prog_data  in  8  byte write data.

Function
REQ-016 Storage: byte array of 2^ADDR_WIDTH entries; byte k of a word is read from (pc+k) mod 2^ADDR_WIDTH, so reads wrap at the top of the array.
REQ-017 Single-entry fetch buffer: data (8*WORD_BYTES), tag (ADDR_WIDTH), and a valid bit; hit = buf_valid AND tag == pc[ADDR_WIDTH-1:0].
REQ-018 FSM states: IDLE and WAIT. From IDLE with fetch_req AND NOT hit, the block goes to WAIT at the next edge, latches pc into req_addr, and loads cnt = LATENCY-1.
REQ-019 In WAIT, cnt decrements each edge. On the edge where cnt == 0, the buffer is filled from req_addr, buf_valid is set to 1, and the state returns to IDLE.
REQ-020 Output busywait = (state == WAIT) OR (fetch_req AND NOT hit), combinational. A miss therefore holds busywait high for exactly LATENCY+1 cycles, counting the request cycle.
REQ-021 Hit: busywait = 0 in the same cycle, and instruction = buffer data combinationally (zero wait).
REQ-022 Outputs: valid = hit; instruction = buffer data when valid, otherwise all-zero.
REQ-023 Output misaligned = (pc mod WORD_BYTES) != 0, combinational. A misaligned fetch still proceeds, reading bytes pc..pc+WORD_BYTES-1 with wrap.
REQ-024 A pc change during WAIT does not abort the fetch in flight. The fill completes for req_addr; the new pc then misses and starts a new fetch from IDLE.
REQ-025 fetch_req low in IDLE: no state change; busywait = 0.
REQ-026 prog_en writes prog_data to the array at prog_addr on the edge.
REQ-027 A prog write to any byte of the buffered word (wrap-aware) clears buf_valid on the same edge.
REQ-028 A prog write to any byte of the in-flight word in WAIT, including on the fill edge, restarts the fetch: cnt reloads LATENCY-1, no fill occurs, and the later fill returns the new data.
REQ-029 prog writes to unrelated addresses do not disturb the buffer or the FSM.
REQ-030 A prog write in the same cycle as a hit read returns the old data in that cycle; valid drops after the edge.

Reset
REQ-031 While reset is high, at the edge: state = IDLE, cnt = 0, buf_valid = 0, req_addr = 0.
REQ-032 While reset is high, outputs SHALL be forced: busywait = 0, valid = 0, instruction = 0. misaligned remains a function of pc.
REQ-033 Reset asserted during WAIT aborts the fetch with no fill. The first request after reset always misses.
REQ-034 Reset does not clear the byte array. A prog write coincident with reset is still performed.

Verification
REQ-035 Defaults. Program bytes 0..3 = 05,00,04,00 and release reset; pc=0, fetch_req=1 -> busywait high for 3 cycles, then instruction=32'h00040005, valid=1, busywait=0.
REQ-036 Back-to-back hit. Hold pc=0 after the fill -> busywait=0 and instruction stable every cycle; pc=4 -> new 3-cycle miss returning bytes 4..7.
REQ-037 Wrap and misalignment. Set pc=1022 with bytes 1022,1023,0,1 = AA,BB,CC,DD -> misaligned=1, instruction=32'hDDCCBBAA after the miss; pc bit 10 set gives an identical result.
REQ-038 Patch coherence. After a hit at pc=8, prog write byte 9=FF -> next cycle valid=0; refetch returns the word with bits [15:8]=FF. A write to byte 10 during WAIT for pc=8 -> busywait extends by LATENCY-cnt cycles and the new data is returned.
REQ-039 Reset mid-fetch. Assert reset in cycle 1 of WAIT -> busywait=0, valid=0, instruction=0; after release the same pc misses again with full latency, and array contents are intact.
REQ-040 Parameter sweep. Run ADDR_WIDTH=6, WORD_BYTES=2, LATENCY=1 -> miss busywait lasts 2 cycles, a 16-bit word is returned, and wrap occurs at 64.
